// File: rtl/cache_arbiter_pkg.sv
// Shared types and access-type encodings for the two-port cache arbiter.
package cache_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } arb_state_t;

   localparam logic [1:0] RW_IDLE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   // 2'b11 is reserved and, like RW_IDLE, never wins arbitration.
   function automatic logic rw_eligible(input logic [1:0] rw);
      return (rw == RW_READ) || (rw == RW_WRITE);
   endfunction

endpackage

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-way round-robin pick: prio selects the winner only when both are eligible.
module rr_pick2 (
   input  logic [1:0] eligible_i,
   input  logic       prio_i,
   output logic [1:0] winner_o
);

   always_comb begin
      winner_o = eligible_i;
      if (eligible_i == 2'b11) begin
         winner_o = prio_i ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Two-requester cache arbiter: IDLE -> ISSUE -> RESP. Define CACHE_ARB_TIMEOUT_EN to bound
// the cache-grant wait to TIMEOUT_CYCLES and report expiry on err_o.
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_i,
   input  logic [1:0]  rw0_i,
   input  logic [1:0]  rw1_i,
   input  logic [11:0] addr0_i,
   input  logic [11:0] addr1_i,
   input  logic [7:0]  wdata0_i,
   input  logic [7:0]  wdata1_i,
   output logic [1:0]  done_o,
   output logic [1:0]  grant_o,
   output logic [7:0]  rdata_o,
   output logic        hit_o,
   output logic [1:0]  err_o,
   output logic        cache_valid_o,
   output logic [1:0]  cache_rw_o,
   output logic [11:0] cache_addr_o,
   output logic [7:0]  cache_wdata_o,
   input  logic [7:0]  cache_rdata_i,
   input  logic        cache_hit_i,
   input  logic        cache_gnt_i
);

   arb_state_t  state_q;
   logic        prio_q;
   logic [1:0]  done_q;
   logic [1:0]  grant_q;
   logic [7:0]  rdata_q;
   logic        hit_q;
   logic        cache_valid_q;
   logic [1:0]  cache_rw_q;
   logic [11:0] cache_addr_q;
   logic [7:0]  cache_wdata_q;

   logic [1:0]  eligible;
   logic [1:0]  winner;

   assign eligible[0] = req_i[0] & rw_eligible(rw0_i);
   assign eligible[1] = req_i[1] & rw_eligible(rw1_i);

   rr_pick2 u_pick (
      .eligible_i (eligible),
      .prio_i     (prio_q),
      .winner_o   (winner)
   );

`ifdef CACHE_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);
   logic [TmoW-1:0] tmo_cnt_q;
   logic [1:0]      err_q;
   assign err_o = err_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign err_o = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         prio_q        <= 1'b0;
         done_q        <= '0;
         grant_q       <= '0;
         rdata_q       <= '0;
         hit_q         <= 1'b0;
         cache_valid_q <= 1'b0;
         cache_rw_q    <= RW_IDLE;
         cache_addr_q  <= '0;
         cache_wdata_q <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         err_q         <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|eligible) begin
                  state_q       <= StIssue;
                  grant_q       <= winner;
                  cache_valid_q <= 1'b1;
                  cache_rw_q    <= winner[1] ? rw1_i    : rw0_i;
                  cache_addr_q  <= winner[1] ? addr1_i  : addr0_i;
                  cache_wdata_q <= winner[1] ? wdata1_i : wdata0_i;
`ifdef CACHE_ARB_TIMEOUT_EN
                  tmo_cnt_q     <= '0;
`endif
               end
            end
            StIssue: begin
               if (cache_gnt_i) begin
                  state_q       <= StResp;
                  cache_valid_q <= 1'b0;
                  done_q        <= grant_q;
                  prio_q        <= grant_q[0];
                  // Writes return no data; don't pass through whatever the cache drives.
                  rdata_q       <= (cache_rw_q == RW_WRITE) ? 8'h00 : cache_rdata_i;
                  hit_q         <= (cache_rw_q == RW_WRITE) ? 1'b0  : cache_hit_i;
               end
`ifdef CACHE_ARB_TIMEOUT_EN
               else if (tmo_cnt_q == TmoMax) begin
                  state_q       <= StResp;
                  cache_valid_q <= 1'b0;
                  done_q        <= grant_q;
                  err_q         <= grant_q;
                  prio_q        <= grant_q[0];
                  rdata_q       <= '0;
                  hit_q         <= 1'b0;
               end else begin
                  tmo_cnt_q     <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            StResp: begin
               state_q       <= StIdle;
               done_q        <= '0;
               grant_q       <= '0;
               rdata_q       <= '0;
               hit_q         <= 1'b0;
               cache_rw_q    <= RW_IDLE;
               cache_addr_q  <= '0;
               cache_wdata_q <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
               err_q         <= '0;
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign done_o        = done_q;
   assign grant_o       = grant_q;
   assign rdata_o       = rdata_q;
   assign hit_o         = hit_q;
   assign cache_valid_o = cache_valid_q;
   assign cache_rw_o    = cache_rw_q;
   assign cache_addr_o  = cache_addr_q;
   assign cache_wdata_o = cache_wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; outputs are sampled 1ns after each rising edge.
module tb_cache_arbiter;
   import cache_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_i;
   logic [1:0]  rw0_i, rw1_i;
   logic [11:0] addr0_i, addr1_i;
   logic [7:0]  wdata0_i, wdata1_i;
   logic [1:0]  done_o, grant_o, err_o;
   logic [7:0]  rdata_o;
   logic        hit_o;
   logic        cache_valid_o;
   logic [1:0]  cache_rw_o;
   logic [11:0] cache_addr_o;
   logic [7:0]  cache_wdata_o;
   logic [7:0]  cache_rdata_i;
   logic        cache_hit_i;
   logic        cache_gnt_i;

   int n_tests = 0;
   int n_fail  = 0;

   cache_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req_i),
      .rw0_i         (rw0_i),
      .rw1_i         (rw1_i),
      .addr0_i       (addr0_i),
      .addr1_i       (addr1_i),
      .wdata0_i      (wdata0_i),
      .wdata1_i      (wdata1_i),
      .done_o        (done_o),
      .grant_o       (grant_o),
      .rdata_o       (rdata_o),
      .hit_o         (hit_o),
      .err_o         (err_o),
      .cache_valid_o (cache_valid_o),
      .cache_rw_o    (cache_rw_o),
      .cache_addr_o  (cache_addr_o),
      .cache_wdata_o (cache_wdata_o),
      .cache_rdata_i (cache_rdata_i),
      .cache_hit_i   (cache_hit_i),
      .cache_gnt_i   (cache_gnt_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " done"},  32'(done_o), 32'h0);
      chk({tag, " grant"}, 32'(grant_o), 32'h0);
      chk({tag, " valid"}, 32'(cache_valid_o), 32'h0);
      chk({tag, " err"},   32'(err_o), 32'h0);
      chk({tag, " rdata"}, 32'(rdata_o), 32'h0);
      chk({tag, " hit"},   32'(hit_o), 32'h0);
   endtask

   initial begin
      rst = 1'b1; req_i = 2'b00;
      rw0_i = RW_IDLE; rw1_i = RW_IDLE;
      addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
      cache_rdata_i = '0; cache_hit_i = 1'b0; cache_gnt_i = 1'b0;
      tick(); tick();
      chk_idle_outputs("reset");
      rst = 1'b0;

      // Single read, grant in cycle 3 -> done in cycle 4
      req_i = 2'b01; rw0_i = RW_READ; addr0_i = 12'h0A5;
      tick();
      chk("rd c1 valid", 32'(cache_valid_o), 32'h1);
      chk("rd c1 addr",  32'(cache_addr_o), 32'h0A5);
      chk("rd c1 rw",    32'(cache_rw_o), 32'(RW_READ));
      chk("rd c1 grant", 32'(grant_o), 32'h1);
      cache_gnt_i = 1'b1; cache_rdata_i = 8'hEE;  // grant outside ISSUE window? no: ignored test below
      cache_gnt_i = 1'b0;
      tick();
      chk("rd c2 valid", 32'(cache_valid_o), 32'h1);
      chk("rd c2 done",  32'(done_o), 32'h0);
      tick();
      cache_gnt_i = 1'b1; cache_rdata_i = 8'h3C; cache_hit_i = 1'b1;
      tick();
      chk("rd c4 done",  32'(done_o), 32'h1);
      chk("rd c4 rdata", 32'(rdata_o), 32'h3C);
      chk("rd c4 hit",   32'(hit_o), 32'h1);
      chk("rd c4 valid", 32'(cache_valid_o), 32'h0);
      chk("rd c4 grant", 32'(grant_o), 32'h1);
      req_i = 2'b00;
      // Grant still high in IDLE must not start or finish anything
      tick();
      chk("rd c5 done",  32'(done_o), 32'h0);
      chk("rd c5 grant", 32'(grant_o), 32'h0);
      tick();
      chk("gnt idle valid", 32'(cache_valid_o), 32'h0);
      chk("gnt idle done",  32'(done_o), 32'h0);
      cache_gnt_i = 1'b0; cache_hit_i = 1'b0;

      // Contention from reset: 0 then 1, then 0 again
      rst = 1'b1; tick(); rst = 1'b0;
      rw0_i = RW_READ; addr0_i = 12'h111; rw1_i = RW_READ; addr1_i = 12'h222;
      for (int pass = 0; pass < 2; pass++) begin
         req_i = 2'b11;
         tick();
         chk("ct grant0", 32'(grant_o), 32'h1);
         chk("ct addr0",  32'(cache_addr_o), 32'h111);
         cache_gnt_i = 1'b1; cache_rdata_i = 8'h11;
         tick();
         chk("ct done0",  32'(done_o), 32'h1);
         chk("ct rdata0", 32'(rdata_o), 32'h11);
         req_i = 2'b10; cache_gnt_i = 1'b0;
         tick();
         chk("ct idle", 32'(cache_valid_o), 32'h0);
         tick();
         chk("ct grant1", 32'(grant_o), 32'h2);
         chk("ct addr1",  32'(cache_addr_o), 32'h222);
         cache_gnt_i = 1'b1; cache_rdata_i = 8'h22;
         tick();
         chk("ct done1",  32'(done_o), 32'h2);
         chk("ct rdata1", 32'(rdata_o), 32'h22);
         req_i = 2'b00; cache_gnt_i = 1'b0;
         tick();
      end

      // Write from requester 1
      req_i = 2'b10; rw1_i = RW_WRITE; addr1_i = 12'hFFF; wdata1_i = 8'hA5;
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("wr valid", 32'(cache_valid_o), 32'h1);
         chk("wr addr",  32'(cache_addr_o), 32'hFFF);
         chk("wr wdata", 32'(cache_wdata_o), 32'hA5);
         chk("wr rw",    32'(cache_rw_o), 32'(RW_WRITE));
         if (i == 0) tick();
      end
      cache_gnt_i = 1'b1; cache_rdata_i = 8'h77; cache_hit_i = 1'b1;
      tick();
      chk("wr done",  32'(done_o), 32'h2);
      chk("wr rdata", 32'(rdata_o), 32'h0);
      chk("wr hit",   32'(hit_o), 32'h0);
      req_i = 2'b00; cache_gnt_i = 1'b0; cache_hit_i = 1'b0;
      tick();

      // Ineligible: RW_IDLE then reserved encoding
      req_i = 2'b01; rw0_i = RW_IDLE;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("inel valid", 32'(cache_valid_o), 32'h0);
         chk("inel done",  32'(done_o), 32'h0);
      end
      rw0_i = 2'b11;
      tick(); tick();
      chk("resv valid", 32'(cache_valid_o), 32'h0);
      req_i = 2'b00;

      // Reset mid-ISSUE after prio has moved to 1
      rw0_i = RW_READ; req_i = 2'b01;
      tick();
      cache_gnt_i = 1'b1;
      tick();
      chk("pre done0", 32'(done_o), 32'h1);
      req_i = 2'b00; cache_gnt_i = 1'b0;
      tick();
      req_i = 2'b10; rw1_i = RW_READ;
      tick();
      chk("mid valid", 32'(cache_valid_o), 32'h1);
      chk("mid grant", 32'(grant_o), 32'h2);
      rst = 1'b1; req_i = 2'b00;
      tick();
      rst = 1'b0;
      chk_idle_outputs("mid rst");
      chk("mid addr", 32'(cache_addr_o), 32'h0);
      tick();
      chk("mid no done", 32'(done_o), 32'h0);
      req_i = 2'b11;
      tick();
      chk("post rst grant", 32'(grant_o), 32'h1);
      cache_gnt_i = 1'b1;
      tick();
      req_i = 2'b00; cache_gnt_i = 1'b0;
      tick();

      // Grant never arrives
      req_i = 2'b01; rw0_i = RW_READ; cache_rdata_i = 8'h5A; cache_hit_i = 1'b1;
      tick();
      chk("tmo c1 valid", 32'(cache_valid_o), 32'h1);
`ifdef CACHE_ARB_TIMEOUT_EN
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk("tmo wait done", 32'(done_o), 32'h0);
      end
      tick();
      chk("tmo done",  32'(done_o), 32'h1);
      chk("tmo err",   32'(err_o), 32'h1);
      chk("tmo rdata", 32'(rdata_o), 32'h0);
      chk("tmo hit",   32'(hit_o), 32'h0);
      req_i = 2'b00;
      tick();
      chk("tmo clear", 32'(err_o), 32'h0);
`else
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("notmo valid", 32'(cache_valid_o), 32'h1);
         chk("notmo done",  32'(done_o), 32'h0);
         chk("notmo err",   32'(err_o), 32'h0);
      end
      rst = 1'b1; req_i = 2'b00;
      tick();
      rst = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
